// File: rtl/alu_pkg.sv
// alu_pkg: shared width, ALU control field type and opcode constants.
// Used by alu_with_control_if, alu_core and alu_with_control.
package alu_pkg;
    localparam int WIDTH = 32;
    typedef logic [3:0] alu_ctl_t;
    localparam alu_ctl_t ALU_AND  = 4'b0000;
    localparam alu_ctl_t ALU_OR   = 4'b0001;
    localparam alu_ctl_t ALU_ADD  = 4'b0010;
    localparam alu_ctl_t ALU_XOR  = 4'b0011;
    localparam alu_ctl_t ALU_SUB  = 4'b0110;
    localparam alu_ctl_t ALU_SLT  = 4'b0111;
    localparam alu_ctl_t ALU_SLTU = 4'b1000;
    localparam alu_ctl_t ALU_NOR  = 4'b1100;
    localparam alu_ctl_t ALU_SLL  = 4'b1101;
    localparam alu_ctl_t ALU_SRL  = 4'b1110;
    localparam alu_ctl_t ALU_SRA  = 4'b1111;
endpackage

// File: rtl/alu_with_control_if.sv
// alu_with_control_if: operand/control bus and registered result/flags of the ALU.
// Signals: A, B (operands), ALUctl (operation), ALUOut (result), Zero ({overflow, zero}).
// master drives operands and reads results; slave is the ALU side.
interface alu_with_control_if;
    import alu_pkg::*;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    alu_ctl_t         ALUctl;
    logic [WIDTH-1:0] ALUOut;
    logic [1:0]       Zero;
    modport master (output A, B, ALUctl, input ALUOut, Zero);
    modport slave  (input A, B, ALUctl, output ALUOut, Zero);
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU result, zero and signed-overflow logic.
// Ports: a_i, b_i operands; ctl_i operation; result_o result; zero_o result==0;
// ovf_o signed overflow (ADD/SUB only).
module alu_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_ctl_t         ctl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o
);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [4:0]       shamt;
    assign sum   = a_i + b_i;
    assign diff  = a_i - b_i;
    assign shamt = a_i[4:0];
    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        case (ctl_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_ADD: begin
                result_o = sum;
                ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SUB: begin
                result_o = diff;
                ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            // Direct signed compare stays correct when a_i - b_i would overflow.
            ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, a_i < b_i};
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_SLL:  result_o = b_i << shamt;
            ALU_SRL:  result_o = b_i >> shamt;
            ALU_SRA:  result_o = $signed(b_i) >>> shamt;
            default:  result_o = '0;
        endcase
    end
    assign zero_o = ~|result_o;
endmodule

// File: rtl/alu_with_control.sv
// alu_with_control: 32-bit ALU with registered result and {overflow, zero} flags.
// Ports: clk, reset (sync, active-high); bus.slave carries A, B, ALUctl in and
// ALUOut, Zero out, one cycle after the operands are sampled.
module alu_with_control
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    alu_with_control_if.slave  bus
);
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic [1:0]       flags_d;
    logic [1:0]       flags_q;
    logic             zero;
    logic             ovf;
    alu_core u_core (
        .a_i      (bus.A),
        .b_i      (bus.B),
        .ctl_i    (bus.ALUctl),
        .result_o (result_d),
        .zero_o   (zero),
        .ovf_o    (ovf)
    );
    assign flags_d = {ovf, zero};
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= 2'b01;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end
    assign bus.ALUOut = result_q;
    assign bus.Zero   = flags_q;
endmodule

// File: tb/tb_alu_with_control.sv
// tb_alu_with_control: scoreboard-based self-checking bench for alu_with_control.
module tb_alu_with_control;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    alu_with_control_if bus ();
    alu_with_control dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] res;
        logic [1:0]  flg;
        string       name;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        logic [31:0] r;
        logic [1:0]  z;
        string       name;
    } vec_t;
    exp_t scb[$];
    int checks = 0;
    int errors = 0;
    vec_t vecs [14] = '{
        '{32'h55555555, 32'hAAAAAAAA, 4'b0000, 32'h00000000, 2'b01, "and"},
        '{32'h55555555, 32'hAAAAAAAA, 4'b0001, 32'hFFFFFFFF, 2'b00, "or"},
        '{32'h55555555, 32'hAAAAAAAA, 4'b0010, 32'hFFFFFFFF, 2'b00, "add"},
        '{32'h55555555, 32'hAAAAAAAA, 4'b0110, 32'hAAAAAAAB, 2'b10, "sub_ovf"},
        '{32'h55555555, 32'hAAAAAAAA, 4'b0111, 32'h00000000, 2'b01, "slt_0"},
        '{32'hAAAAAAAA, 32'h55555555, 4'b0111, 32'h00000001, 2'b00, "slt_1"},
        '{32'hAAAAAAAA, 32'h55555555, 4'b1000, 32'h00000000, 2'b01, "sltu"},
        '{32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 2'b10, "add_ovf"},
        '{32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 2'b01, "add_wrap"},
        '{32'h00000004, 32'h80000001, 4'b1101, 32'h00000010, 2'b00, "sll"},
        '{32'h00000004, 32'h80000001, 4'b1110, 32'h08000000, 2'b00, "srl"},
        '{32'h00000004, 32'h80000001, 4'b1111, 32'hF8000000, 2'b00, "sra"},
        '{32'h00000020, 32'h80000001, 4'b1101, 32'h80000001, 2'b00, "sll_amt0"},
        '{32'h00000004, 32'h80000001, 4'b0100, 32'h00000000, 2'b01, "undef"}
    };

    // Reference model built on 64-bit signed arithmetic: overflow is detected
    // as the true sum/difference not fitting in 32 signed bits.
    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [3:0] c);
        exp_t   e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        e.res = '0;
        e.flg = '0;
        e.name = "rand";
        case (c)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0011: e.res = a ^ b;
            4'b0010, 4'b0110: begin
                s = (c == 4'b0010) ? sa + sb : sa - sb;
                e.res = s[31:0];
                e.flg[1] = s != longint'($signed(e.res));
            end
            4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b1100: e.res = ~(a | b);
            4'b1101: e.res = b << a[4:0];
            4'b1110: e.res = b >> a[4:0];
            4'b1111: begin
                s = sb >>> a[4:0];
                e.res = s[31:0];
            end
            default: e.res = '0;
        endcase
        e.flg[0] = (e.res == 32'd0);
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.A = '0;
        bus.B = '0;
        bus.ALUctl = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.ALUOut !== 32'h0 || bus.Zero !== 2'b01) begin
                errors++;
                $display("FAIL reset_hold%0d: got %h/%b expected 00000000/01", i, bus.ALUOut, bus.Zero);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        scb.push_back('{32'h0, 2'b01, "reset_release"});
        @(posedge clk);
        #1;
        begin
            exp_t e = scb.pop_front();
            checks++;
            if (bus.ALUOut !== e.res || bus.Zero !== e.flg) begin
                errors++;
                $display("FAIL %s: got %h/%b expected %h/%b", e.name, bus.ALUOut, bus.Zero, e.res, e.flg);
            end
        end
        // Reset must win over a live operation producing a non-zero result.
        @(negedge clk);
        bus.A = 32'h55555555;
        bus.B = 32'hAAAAAAAA;
        bus.ALUctl = ALU_OR;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ALUOut !== 32'h0 || bus.Zero !== 2'b01) begin
            errors++;
            $display("FAIL reset_priority: got %h/%b expected 00000000/01", bus.ALUOut, bus.Zero);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.A = vecs[i].a;
            bus.B = vecs[i].b;
            bus.ALUctl = vecs[i].c;
            scb.push_back('{vecs[i].r, vecs[i].z, vecs[i].name});
            @(posedge clk);
            #1;
            if (scb.size() == 0) begin
                errors++;
                $display("FAIL %s: scoreboard empty", vecs[i].name);
            end else begin
                exp_t e = scb.pop_front();
                checks++;
                if (bus.ALUOut !== e.res) begin
                    errors++;
                    $display("FAIL %s result: got %h expected %h", e.name, bus.ALUOut, e.res);
                end
                checks++;
                if (bus.Zero !== e.flg) begin
                    errors++;
                    $display("FAIL %s flags: got %b expected %b", e.name, bus.Zero, e.flg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev_res = bus.ALUOut;
        logic [1:0]  prev_flg = bus.Zero;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            logic [3:0]  c = 4'($urandom_range(0, 15));
            if (i % 4 == 0) a[31:5] = '0;
            if (i % 5 == 0) b = ~a;
            @(negedge clk);
            bus.A = a;
            bus.B = b;
            bus.ALUctl = c;
            scb.push_back(model(a, b, c));
            #1;
            // New operands must not reach the outputs before the next edge.
            checks++;
            if (bus.ALUOut !== prev_res || bus.Zero !== prev_flg) begin
                errors++;
                $display("FAIL latency%0d: got %h/%b expected held %h/%b", i, bus.ALUOut, bus.Zero, prev_res, prev_flg);
            end
            @(posedge clk);
            #1;
            begin
                exp_t e = scb.pop_front();
                checks++;
                if (bus.ALUOut !== e.res || bus.Zero !== e.flg) begin
                    errors++;
                    $display("FAIL rand%0d a=%h b=%h ctl=%b: got %h/%b expected %h/%b", i, a, b, c, bus.ALUOut, bus.Zero, e.res, e.flg);
                end
                prev_res = e.res;
                prev_flg = e.flg;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
